ahb_slave_mem_model: RTL and testbench
======================================

Name: ahb_slave_mem_model

Overview:
- Parametrised AHB-Lite slave memory model that succeeds the fixed-width, zero-wait mock peripheral used in the DMAC benches.
- Adds configurable data width, wait-state insertion, byte/halfword/word writes with lane strobing, and a two-cycle ERROR response for a programmable faulting address window and for bad accesses.
- Sits on the DMAC master port in top-level benches as a DMA source or destination, so the DMAC's M_HResp/HReady paths can be exercised.

Parameters:
- DATA_WIDTH, 32: HWDATA/HRDATA width; must be 32 or 64.
- ADDR_WIDTH, 32: HADDR width.
- MEM_DEPTH, 256: number of DATA_WIDTH words in the array named mem, which benches preload hierarchically.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in each OKAY data phase.
- ERR_LO, 32'hFFFF_FFFF: first byte address of the error window, inclusive.
- ERR_HI, 32'h0000_0000: last byte address of the error window, inclusive. ERR_LO > ERR_HI disables the window.

Ports:
- HCLK, input, 1: clock.
- HRESET, input, 1: asynchronous active-high reset.
- HSEL, input, 1: slave select.
- HADDR, input, ADDR_WIDTH: byte address.
- HTRANS, input, 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE, input, 1: 1 = write.
- HSIZE, input, 3: transfer size, log2 of the byte count.
- HREADYIN, input, 1: bus ready.
- HWDATA, input, DATA_WIDTH: write data, valid in the data phase.
- HRDATA, output, DATA_WIDTH: read data.
- HREADYOUT, output, 1: slave ready.
- HRESP, output, 2: 00 OKAY, 01 ERROR.

Behaviour:
- Byte-lane and index constants:
  - NB = DATA_WIDTH/8.
  - LB = log2(NB).
  - Word index = HADDR[LB+log2(MEM_DEPTH)-1 : LB]. Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH*NB.
- Address-phase accept: a transfer is accepted when HSEL && HTRANS[1] && HREADYIN && HREADYOUT. On accept, the address, write, size and error flag are registered.
  - IDLE or BUSY, or HSEL=0: not accepted; the next data phase is OKAY with zero wait.
- Error flag is set when any of the following holds:
  - the address lies in [ERR_LO, ERR_HI];
  - HSIZE > LB;
  - the address is misaligned to HSIZE, i.e. HADDR mod 2^HSIZE != 0.
- FSM states are IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=OKAY.
    - Accept with error → ERR1.
    - Accept with no error and WAIT_STATES>0 → WAIT, with the counter loaded to WAIT_STATES-1.
    - Accept with no error and WAIT_STATES=0 → the data phase completes in IDLE in the next cycle.
  - WAIT: HREADYOUT=0, HRESP=OKAY. The counter decrements each cycle; at 0 → IDLE, where the data phase completes with HREADYOUT=1.
  - ERR1: HREADYOUT=0, HRESP=ERROR → ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR → IDLE. A new transfer may be accepted in ERR2.
- OKAY data-phase latency is WAIT_STATES+1 cycles after the address phase.
- Write data phase: mem is updated on the HCLK edge where HREADYOUT=1 closes the phase. Only the lanes selected by size and the low address bits are written, little-endian. Erroring writes do not modify mem.
- Read data phase: HRDATA = mem[registered index], full word, driven while the completing cycle has HREADYOUT=1. HRDATA is 0 during waits, error phases, writes and idle.
- Back-to-back write then read to the same word: the read returns the newly written data, with no hazard.
- Pipelining: an address phase may overlap the completing data phase; this gives full-throughput bursts when WAIT_STATES=0.
- Reset (asynchronous, any time, including mid-wait or mid-error):
  - state=IDLE, counter=0, HREADYOUT=1, HRESP=00, HRDATA=0, registered phase cleared.
  - mem is not reset.

Optional Feature:
- Macro: AHB_MEM_RAND_WAIT_EN.
- Defined: a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per accepted transfer. That transfer's wait count = LFSR[7:0] mod (WAIT_STATES+1), so it falls in 0..WAIT_STATES.
- Undefined: the wait count is fixed at WAIT_STATES and there is no LFSR logic.

Test Plan:
1. Reset and read: reset asserted, mem[3]=32'hDEADBEEF preloaded, NONSEQ read at 0x0C, WAIT_STATES=0 → next cycle HREADYOUT=1, HRESP=00, HRDATA=32'hDEADBEEF.
2. Wait states: WAIT_STATES=2, NONSEQ read at 0x00 holding 32'h11223344 → HREADYOUT low exactly 2 cycles, then high with data 32'h11223344 and HRESP=00.
3. Byte-lane write: HSIZE=0 write of 32'hXXXXAAXX to 0x05 over mem[1]=0 → mem[1]=32'h0000AA00. Halfword write 32'hBEEF0000 to 0x06 → mem[1]=32'hBEEFAA00.
4. Error window: ERR_LO=0x100, ERR_HI=0x1FF, write 32'h5 to 0x104 → two-cycle ERROR (HREADYOUT 0 then 1, HRESP=01) and mem[65] unchanged. Misaligned word read at 0x02 → same two-cycle ERROR.
5. Burst throughput: 18-beat NONSEQ/SEQ read from 0x0, WAIT_STATES=0 → 18 consecutive HREADYOUT=1 data phases returning mem[0..17] in order. Address 0x400 with MEM_DEPTH=256 wraps to mem[0].
6. Reset mid-wait: WAIT_STATES=3, HRESET pulsed during the second wait cycle → HREADYOUT=1, HRESP=00 and HRDATA=0 immediately. A write in flight is not committed.

Source files
------------

// File: rtl/ahb_slave_mem_model.sv
`default_nettype none
// ---------------------------------------------------------------------------------------
// ahb_slave_mem_model : AHB-Lite slave memory, wait states, lane writes, 2-cycle ERROR. Rev 1.0
// Option macro AHB_MEM_RAND_WAIT_EN : LFSR-randomised per-transfer wait count.
// ---------------------------------------------------------------------------------------
module ahb_slave_mem_model #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ERR_LO      = 32'hFFFF_FFFF,
  parameter logic [31:0] ERR_HI      = 32'h0000_0000
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic                  HREADYIN,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ph_valid_q, ph_valid_d;
  logic            ph_write_q, ph_write_d;
  logic [IW-1:0]   ph_idx_q, ph_idx_d;
  logic [LB-1:0]   ph_lo_q, ph_lo_d;
  logic [2:0]      ph_size_q, ph_size_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic            w_accept;
  logic            w_err;
  logic            w_complete;
  logic [CW-1:0]   w_wait;
  logic [NB-1:0]   w_strb;
  logic [63:0]     w_addr64;
  logic [2:0]      w_amask;
  logic            w_unused_htrans0;

  assign w_addr64         = 64'(HADDR);
  assign w_unused_htrans0 = HTRANS[0];
  assign w_amask          = 3'((4'd1 << HSIZE) - 4'd1);

  assign HREADYOUT  = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign HRESP      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
  assign w_accept   = HSEL && HTRANS[1] && HREADYIN && HREADYOUT;
  assign w_complete = (state_q == ST_IDLE) && ph_valid_q;

  // An empty window (ERR_LO > ERR_HI) can never match, so no explicit enable is needed.
  assign w_err = ((w_addr64 >= 64'(ERR_LO)) && (w_addr64 <= 64'(ERR_HI)))
              || (HSIZE > 3'(LB))
              || ((HADDR[2:0] & w_amask) != 3'd0);

`ifdef AHB_MEM_RAND_WAIT_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      lfsr_q <= 16'hACE1;
    end else if (w_accept) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_wait = CW'(32'(lfsr_q[7:0]) % (WAIT_STATES + 1));
`else
  assign w_wait = CW'(WAIT_STATES);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ph_valid_d = ph_valid_q && !w_complete;
    ph_write_d = ph_write_q;
    ph_idx_d   = ph_idx_q;
    ph_lo_d    = ph_lo_q;
    ph_size_d  = ph_size_q;

    if (w_accept && !w_err) begin
      ph_valid_d = 1'b1;
      ph_write_d = HWRITE;
      ph_idx_d   = HADDR[LB+IW-1:LB];
      ph_lo_d    = HADDR[LB-1:0];
      ph_size_d  = HSIZE;
    end

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (w_accept) begin
          if (w_err) begin
            state_d = ST_ERR1;
          end else if (w_wait != '0) begin
            state_d = ST_WAIT;
            cnt_d   = w_wait - CW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ph_valid_q <= 1'b0;
      ph_write_q <= 1'b0;
      ph_idx_q   <= '0;
      ph_lo_q    <= '0;
      ph_size_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_valid_q <= ph_valid_d;
      ph_write_q <= ph_write_d;
      ph_idx_q   <= ph_idx_d;
      ph_lo_q    <= ph_lo_d;
      ph_size_q  <= ph_size_d;
    end
  end

  // Little-endian lanes: bytes [lo, lo + 2^size) of the addressed word.
  always_comb begin
    w_strb = '0;
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(ph_lo_q)) && (b < int'(ph_lo_q) + (1 << ph_size_q))) w_strb[b] = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_complete && ph_write_q) begin
      for (int b = 0; b < NB; b++) begin
        if (w_strb[b]) mem[ph_idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

  assign HRDATA = (w_complete && !ph_write_q) ? mem[ph_idx_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem_model.sv
`default_nettype none
// tb_ahb_slave_mem_model : directed scoreboard bench over three instances (0, 2 and 3 wait states).
module tb_ahb_slave_mem_model;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  int          cur = 0;

  logic [31:0] rd0, rd2, rd3;
  logic        ro0, ro2, ro3;
  logic [1:0]  rs0, rs2, rs3;
  logic        hreadyin;
  logic [31:0] obs_rd;
  logic        obs_ry;
  logic [1:0]  obs_rs;

  always #5 clk = ~clk;

  assign hreadyin = ro0 & ro2 & ro3;

  always_comb begin
    obs_rd = rd3; obs_ry = ro3; obs_rs = rs3;
    case (cur)
      0: begin obs_rd = rd0; obs_ry = ro0; obs_rs = rs0; end
      2: begin obs_rd = rd2; obs_ry = ro2; obs_rs = rs2; end
      default: ;
    endcase
  end

  ahb_slave_mem_model #(.WAIT_STATES(0), .ERR_LO(32'h100), .ERR_HI(32'h1FF)) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(cur == 0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(hreadyin), .HWDATA(hwdata),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));

  ahb_slave_mem_model #(.WAIT_STATES(2)) u2 (
    .HCLK(clk), .HRESET(rst), .HSEL(cur == 2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(hreadyin), .HWDATA(hwdata),
    .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(rs2));

  ahb_slave_mem_model #(.WAIT_STATES(3)) u3 (
    .HCLK(clk), .HRESET(rst), .HSEL(cur == 3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(hreadyin), .HWDATA(hwdata),
    .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        wr;
    logic        err;
    logic [2:0]  size;
    logic [1:0]  trans;
  } xfer_t;

  xfer_t       stim[$];
  xfer_t       sb[$];
  xfer_t       pend;
  logic        pend_v;
  logic [31:0] model [256];
  int          vectors = 0;
  int          miscompares = 0;
  int          first_c, last_c, ncomp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of();
    return (cur == 0) ? 0 : (cur == 2) ? 2 : 3;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic [2:0] s);
    logic win;
    win = (cur == 0) && (a >= 32'h100) && (a <= 32'h1FF);
    return win || (s > 3'd2) || ((a & ((32'd1 << s) - 32'd1)) != 32'd0);
  endfunction

  task automatic poke(input int idx, input logic [31:0] v);
    model[idx] = v;
    case (cur)
      0: u0.mem[idx] = v;
      2: u2.mem[idx] = v;
      default: u3.mem[idx] = v;
    endcase
  endtask

  function automatic logic [31:0] peek(input int idx);
    case (cur)
      0: return u0.mem[idx];
      2: return u2.mem[idx];
      default: return u3.mem[idx];
    endcase
  endfunction

  // Queue one transfer; the reference memory is updated in program order.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] s,
                      input logic [31:0] d, input logic [1:0] tr);
    xfer_t t;
    int    idx;
    int    lo;
    t.addr = a; t.wr = w; t.size = s; t.wdata = d; t.trans = tr;
    t.err = exp_err(a, s);
    t.exp_rd = '0;
    idx = int'(a[9:2]);
    lo  = int'(a[1:0]);
    if (!t.err && !w) t.exp_rd = model[idx];
    if (!t.err && w) begin
      for (int b = 0; b < 4; b++) begin
        if (b >= lo && b < lo + (1 << s)) model[idx][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    stim.push_back(t);
  endtask

  // Pipelined master: drives queued transfers, pops the scoreboard on each completing data phase.
  task automatic run(input string tag);
    int          waits = 0;
    int          budget = 0;
    int          cyc = 0;
    logic [1:0]  low_rs = '0;
    logic [31:0] low_rd = '0;
    logic        prev_ready = 1'b1;
    pend_v = 1'b0;
    sb.delete();
    first_c = -1; last_c = -1; ncomp = 0;
    while ((stim.size() != 0 || pend_v || sb.size() != 0) && budget < 200) begin
      if (prev_ready && pend_v) begin
        sb.push_back(pend);
        pend_v = 1'b0;
        if (pend.wr) hwdata = pend.wdata;
      end
      if (sb.size() != 0) begin
        if (obs_ry) begin
          xfer_t h;
          h = sb.pop_front();
          chk({tag, " resp"},    32'(obs_rs), h.err ? 32'd1 : 32'd0);
          chk({tag, " rdata"},   obs_rd, h.exp_rd);
          chk({tag, " waits"},   32'(waits), h.err ? 32'd1 : 32'(ws_of()));
          chk({tag, " wait rs"}, 32'(low_rs), h.err ? 32'd1 : 32'd0);
          chk({tag, " wait rd"}, low_rd, 32'd0);
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
          ncomp++;
          waits = 0; low_rs = '0; low_rd = '0;
        end else begin
          waits++;
          low_rs = low_rs | obs_rs;
          low_rd = low_rd | obs_rd;
        end
      end
      if (!pend_v) begin
        if (stim.size() != 0) begin
          pend   = stim.pop_front();
          pend_v = 1'b1;
          haddr  = pend.addr;
          hwrite = pend.wr;
          hsize  = pend.size;
          htrans = pend.trans;
        end else begin
          htrans = 2'b00;
          hwrite = 1'b0;
        end
      end
      prev_ready = obs_ry;
      @(posedge clk); #1;
      budget++;
      cyc++;
    end
    if (budget >= 200) chk({tag, " timeout"}, 32'(budget), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      model[i] = '0; u0.mem[i] = '0; u2.mem[i] = '0; u3.mem[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready u0", 32'(ro0), 32'd1);
    chk("rst ready u3", 32'(ro3), 32'd1);
    chk("rst resp u2",  32'(rs2), 32'd0);
    chk("rst rdata u2", rd2, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait read
    cur = 0;
    poke(3, 32'hDEADBEEF);
    xfer(32'h0C, 1'b0, 3'd2, 32'h0, 2'b10);
    run("t1 read");

    // BUSY must not be accepted
    haddr = 32'h0C; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b01;
    @(posedge clk); #1;
    chk("busy ready", 32'(obs_ry), 32'd1);
    chk("busy rdata", obs_rd, 32'd0);
    htrans = 2'b00;

    // Lane writes, readback and write-then-read hazard
    poke(1, 32'h0);
    xfer(32'h05, 1'b1, 3'd0, 32'h1234AA56, 2'b10);
    xfer(32'h06, 1'b1, 3'd1, 32'hBEEF1357, 2'b10);
    xfer(32'h04, 1'b0, 3'd2, 32'h0, 2'b10);
    xfer(32'h08, 1'b1, 3'd2, 32'hA5A5_5A5A, 2'b10);
    xfer(32'h08, 1'b0, 3'd2, 32'h0, 2'b10);
    xfer(32'h0B, 1'b1, 3'd0, 32'h77000000, 2'b10);
    xfer(32'h08, 1'b0, 3'd2, 32'h0, 2'b10);
    run("t3 lanes");
    chk("t3 mem1", peek(1), 32'hBEEFAA00);

    // Error window and bad accesses; new transfer accepted in ERR2
    poke(65, 32'h0BADF00D);
    poke(128, 32'h12345678);
    poke(63, 32'h0F0F0F0F);
    xfer(32'h104, 1'b1, 3'd2, 32'h5, 2'b10);
    xfer(32'h02,  1'b0, 3'd2, 32'h0, 2'b10);
    xfer(32'h00,  1'b0, 3'd3, 32'h0, 2'b10);
    xfer(32'h0C,  1'b0, 3'd2, 32'h0, 2'b10);
    xfer(32'h100, 1'b0, 3'd2, 32'h0, 2'b10);
    xfer(32'h1FF, 1'b0, 3'd0, 32'h0, 2'b10);
    xfer(32'h200, 1'b0, 3'd2, 32'h0, 2'b10);
    xfer(32'hFC,  1'b0, 3'd2, 32'h0, 2'b10);
    run("t4 err");
    chk("t4 mem65", peek(65), 32'h0BADF00D);

    // 18-beat burst at full throughput, then address wrap
    for (int i = 0; i < 18; i++) poke(i, 32'h0101_0101 * i + 32'h100);
    for (int i = 0; i < 18; i++) xfer(32'(i * 4), 1'b0, 3'd2, 32'h0, (i == 0) ? 2'b10 : 2'b11);
    run("t5 burst");
    chk("t5 beats", 32'(ncomp), 32'd18);
    chk("t5 span",  32'(last_c - first_c), 32'd17);
    xfer(32'h400, 1'b0, 3'd2, 32'h0, 2'b10);
    run("t5 wrap");

    // Wait states
    cur = 2;
    poke(0, 32'h11223344);
    xfer(32'h00, 1'b0, 3'd2, 32'h0, 2'b10);
    xfer(32'h20, 1'b1, 3'd2, 32'hCAFE_F00D, 2'b10);
    xfer(32'h20, 1'b0, 3'd2, 32'h0, 2'b10);
    run("t2 wait");

    // Reset during the second wait cycle of a write
    cur = 3;
    poke(4, 32'h55667788);
    haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge clk); #1;
    chk("t6 wait1 ready", 32'(obs_ry), 32'd0);
    htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("t6 wait2 ready", 32'(obs_ry), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6 rst ready", 32'(obs_ry), 32'd1);
    chk("t6 rst resp",  32'(obs_rs), 32'd0);
    chk("t6 rst rdata", obs_rd, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6 no commit", peek(4), 32'h55667788);
    xfer(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
    run("t6 read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
